// File: rtl/syn_gpu_pkg.sv
// Shared widths, access kinds and read-tag encodings for the SRAM arbiter
// and its pad-side register stage.
package syn_gpu_pkg;

  localparam int P_SRAM_ADDR_W = 18;
  localparam int P_SRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    SRAM_IDLE,
    SRAM_VGA_RD,
    SRAM_GPU_RD,
    SRAM_GPU_WR
  } sram_acc_kind_t;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_RD,
    DIR_WR
  } sram_dir_t;

  // Bit positions of the one-hot access vector handed to the pad stage.
  localparam int OH_VGA_RD = 0;
  localparam int OH_GPU_RD = 1;
  localparam int OH_GPU_WR = 2;

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_VGA  = 2'd1;
  localparam logic [1:0] TAG_GPU  = 2'd2;

  function automatic logic [2:0] kind_to_onehot(input sram_acc_kind_t kind);
    logic [2:0] oh;
    oh = '0;
    case (kind)
      SRAM_VGA_RD: oh[OH_VGA_RD] = 1'b1;
      SRAM_GPU_RD: oh[OH_GPU_RD] = 1'b1;
      SRAM_GPU_WR: oh[OH_GPU_WR] = 1'b1;
      default:     oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/syn_sram_phy_if.sv
// Pad-side register stage: registers address, strobes and write data one
// cycle after a grant, captures read data and routes it by a 2-bit tag.
module syn_sram_phy_if
  import syn_gpu_pkg::*;
(
  input  logic                     clk_ir,
  input  logic                     rst_sync,
  input  logic [2:0]               acc_oh,
  input  logic [P_SRAM_ADDR_W-1:0] acc_addr,
  input  logic [P_SRAM_DATA_W-1:0] acc_wdata,
  output logic [P_SRAM_ADDR_W-1:0] sram_addr,
  output logic [P_SRAM_DATA_W-1:0] sram_dq_out,
  output logic                     sram_dq_oe,
  input  logic [P_SRAM_DATA_W-1:0] sram_dq_in,
  output logic                     sram_ce_n,
  output logic                     sram_oe_n,
  output logic                     sram_we_n,
  output logic                     sram_lb_n,
  output logic                     sram_ub_n,
  output logic [P_SRAM_DATA_W-1:0] vga_rd_data,
  output logic                     vga_rd_valid,
  output logic [P_SRAM_DATA_W-1:0] gpu_rd_data,
  output logic                     gpu_rd_valid
);

  logic [P_SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [P_SRAM_DATA_W-1:0] dq_out_q, dq_out_d;
  logic [P_SRAM_DATA_W-1:0] vga_data_q, vga_data_d, gpu_data_q, gpu_data_d;
  logic [1:0]               tag_q, tag_d;
  logic dq_oe_q, dq_oe_d, ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic vga_valid_q, vga_valid_d, gpu_valid_q, gpu_valid_d;
  logic bytes_n_q;
  logic issue, is_rd;

  always_comb begin
    issue    = |acc_oh;
    is_rd    = acc_oh[OH_VGA_RD] | acc_oh[OH_GPU_RD];
    addr_d   = issue ? acc_addr : addr_q;
    dq_out_d = acc_oh[OH_GPU_WR] ? acc_wdata : dq_out_q;
    dq_oe_d  = acc_oh[OH_GPU_WR];
    ce_n_d   = ~issue;
    oe_n_d   = ~is_rd;
    we_n_d   = ~acc_oh[OH_GPU_WR];
    tag_d    = acc_oh[OH_VGA_RD] ? TAG_VGA : (acc_oh[OH_GPU_RD] ? TAG_GPU : TAG_NONE);
    // tag_q marks the cycle the pads are being read; data is captured at its end.
    vga_valid_d = (tag_q == TAG_VGA);
    gpu_valid_d = (tag_q == TAG_GPU);
    vga_data_d  = vga_valid_d ? sram_dq_in : vga_data_q;
    gpu_data_d  = gpu_valid_d ? sram_dq_in : gpu_data_q;
  end

  always_ff @(posedge clk_ir) begin
    if (rst_sync) begin
      addr_q      <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      bytes_n_q   <= 1'b1;
      tag_q       <= TAG_NONE;
      vga_valid_q <= 1'b0;
      gpu_valid_q <= 1'b0;
      vga_data_q  <= '0;
      gpu_data_q  <= '0;
    end else begin
      addr_q      <= addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      bytes_n_q   <= 1'b0;
      tag_q       <= tag_d;
      vga_valid_q <= vga_valid_d;
      gpu_valid_q <= gpu_valid_d;
      vga_data_q  <= vga_data_d;
      gpu_data_q  <= gpu_data_d;
    end
  end

  assign sram_addr    = addr_q;
  assign sram_dq_out  = dq_out_q;
  assign sram_dq_oe   = dq_oe_q;
  assign sram_ce_n    = ce_n_q;
  assign sram_oe_n    = oe_n_q;
  assign sram_we_n    = we_n_q;
  assign sram_lb_n    = bytes_n_q;
  assign sram_ub_n    = bytes_n_q;
  assign vga_rd_data  = vga_data_q;
  assign vga_rd_valid = vga_valid_q;
  assign gpu_rd_data  = gpu_data_q;
  assign gpu_rd_valid = gpu_valid_q;

endmodule

// File: rtl/syn_sram_acc_arb.sv
// Shares one async SRAM between the VGA read stream and the GPU port: VGA
// priority with bounded GPU starvation, one bubble per direction change.
module syn_sram_acc_arb
  import syn_gpu_pkg::*;
#(
  parameter int P_VGA_BURST_MAX = 8
) (
  input  logic                     clk_ir,
  input  logic                     rst_sync,
  input  logic                     vga_rd_en,
  input  logic [P_SRAM_ADDR_W-1:0] vga_addr,
  output logic                     vga_rdy,
  output logic [P_SRAM_DATA_W-1:0] vga_rd_data,
  output logic                     vga_rd_valid,
  input  logic                     gpu_rd_en,
  input  logic                     gpu_wr_en,
  input  logic [P_SRAM_ADDR_W-1:0] gpu_addr,
  input  logic [P_SRAM_DATA_W-1:0] gpu_wr_data,
  output logic                     gpu_rdy,
  output logic [P_SRAM_DATA_W-1:0] gpu_rd_data,
  output logic                     gpu_rd_valid,
  output logic [P_SRAM_ADDR_W-1:0] sram_addr,
  output logic [P_SRAM_DATA_W-1:0] sram_dq_out,
  output logic                     sram_dq_oe,
  input  logic [P_SRAM_DATA_W-1:0] sram_dq_in,
  output logic                     sram_ce_n,
  output logic                     sram_oe_n,
  output logic                     sram_we_n,
  output logic                     sram_lb_n,
  output logic                     sram_ub_n,
  output logic                     gpu_starve
);

  localparam int CNT_W = $clog2(P_VGA_BURST_MAX + 1);

  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  sram_dir_t        last_dir_q, last_dir_d, cand_dir;
  sram_acc_kind_t   cand_kind, acc_kind;
  logic             gpu_req, burst_full, bubble;
  logic [P_SRAM_ADDR_W-1:0] acc_addr;

  // Handshake: a request is taken in the cycle where its *_en and *_rdy are
  // both high; rdy is a same-cycle grant and never high for both ports.
  always_comb begin
    gpu_req    = gpu_rd_en | gpu_wr_en;
    burst_full = (burst_cnt_q == CNT_W'(P_VGA_BURST_MAX));
    cand_kind  = SRAM_IDLE;
    if (vga_rd_en && !(gpu_req && burst_full)) cand_kind = SRAM_VGA_RD;
    else if (gpu_req) cand_kind = gpu_wr_en ? SRAM_GPU_WR : SRAM_GPU_RD;
    cand_dir = (cand_kind == SRAM_IDLE) ? DIR_NONE :
               ((cand_kind == SRAM_GPU_WR) ? DIR_WR : DIR_RD);
    bubble   = (cand_dir != DIR_NONE) && (last_dir_q != DIR_NONE) && (cand_dir != last_dir_q);
    acc_kind = (bubble || rst_sync) ? SRAM_IDLE : cand_kind;

    vga_rdy    = (acc_kind == SRAM_VGA_RD);
    gpu_rdy    = (acc_kind == SRAM_GPU_RD) || (acc_kind == SRAM_GPU_WR);
    gpu_starve = gpu_rdy && vga_rd_en && burst_full;
    acc_addr   = vga_rdy ? vga_addr : gpu_addr;

    last_dir_d = (acc_kind == SRAM_IDLE) ? DIR_NONE : cand_dir;
    burst_cnt_d = burst_cnt_q;
    if (!gpu_req || gpu_rdy) burst_cnt_d = '0;
    else if (vga_rdy && !burst_full) burst_cnt_d = burst_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_ir) begin
    if (rst_sync) begin
      burst_cnt_q <= '0;
      last_dir_q  <= DIR_NONE;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      last_dir_q  <= last_dir_d;
    end
  end

  syn_sram_phy_if u_phy (
    .clk_ir       (clk_ir),
    .rst_sync     (rst_sync),
    .acc_oh       (kind_to_onehot(acc_kind)),
    .acc_addr     (acc_addr),
    .acc_wdata    (gpu_wr_data),
    .sram_addr    (sram_addr),
    .sram_dq_out  (sram_dq_out),
    .sram_dq_oe   (sram_dq_oe),
    .sram_dq_in   (sram_dq_in),
    .sram_ce_n    (sram_ce_n),
    .sram_oe_n    (sram_oe_n),
    .sram_we_n    (sram_we_n),
    .sram_lb_n    (sram_lb_n),
    .sram_ub_n    (sram_ub_n),
    .vga_rd_data  (vga_rd_data),
    .vga_rd_valid (vga_rd_valid),
    .gpu_rd_data  (gpu_rd_data),
    .gpu_rd_valid (gpu_rd_valid)
  );

endmodule

// File: tb/tb_syn_sram_acc_arb.sv
// Bench for syn_sram_acc_arb: vector table, directed corner sequences and a
// random run, all checked against a behavioural SRAM/arbitration model.
module tb_syn_sram_acc_arb;
  import syn_gpu_pkg::*;

  localparam int AW = P_SRAM_ADDR_W;
  localparam int DW = P_SRAM_DATA_W;
  localparam int BMAX = 8;

  // clock / reset
  logic clk_ir = 1'b0;
  always #5 clk_ir = ~clk_ir;
  logic rst_sync;

  logic          vga_rd_en, vga_rdy, vga_rd_valid;
  logic [AW-1:0] vga_addr;
  logic [DW-1:0] vga_rd_data;
  logic          gpu_rd_en, gpu_wr_en, gpu_rdy, gpu_rd_valid, gpu_starve;
  logic [AW-1:0] gpu_addr;
  logic [DW-1:0] gpu_wr_data, gpu_rd_data;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dq_out, sram_dq_in;
  logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

  syn_sram_acc_arb #(.P_VGA_BURST_MAX(BMAX)) dut (
    .clk_ir(clk_ir), .rst_sync(rst_sync),
    .vga_rd_en(vga_rd_en), .vga_addr(vga_addr), .vga_rdy(vga_rdy),
    .vga_rd_data(vga_rd_data), .vga_rd_valid(vga_rd_valid),
    .gpu_rd_en(gpu_rd_en), .gpu_wr_en(gpu_wr_en), .gpu_addr(gpu_addr),
    .gpu_wr_data(gpu_wr_data), .gpu_rdy(gpu_rdy), .gpu_rd_data(gpu_rd_data),
    .gpu_rd_valid(gpu_rd_valid),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n),
    .gpu_starve(gpu_starve)
  );

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'(a * 16'h0101) ^ 16'h5A00;
  endfunction

  // SRAM pad model: async read, write on the edge that ends a we_n-low cycle
  logic [DW-1:0] pad_mem [0:1023];
  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? pad_mem[sram_addr[9:0]] : 16'hDEAD;
  initial begin
    for (int i = 0; i < 1024; i++) pad_mem[i] = init_val(i);
    forever begin
      @(posedge clk_ir);
      if (!sram_ce_n && !sram_we_n && sram_dq_oe) pad_mem[sram_addr[9:0]] = sram_dq_out;
    end
  end

  // scoreboard
  int errors = 0;
  int checks = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: kind 0 none, 1 VGA read, 2 GPU read, 3 GPU write
  typedef struct { int kind; logic [AW-1:0] addr; logic [DW-1:0] data; } op_t;
  logic [DW-1:0] ref_mem [0:1023];
  op_t m_prev, m_prev2;
  int  m_burst, m_dir;
  logic obs_vga_rdy, obs_gpu_rdy, obs_starve, obs_vga_valid, obs_gpu_valid, obs_we_n;
  logic [DW-1:0] obs_gpu_data;

  task automatic model_clear();
    m_prev  = '{0, '0, '0};
    m_prev2 = '{0, '0, '0};
    m_burst = 0;
    m_dir   = 0;
  endtask

  // one clock cycle: drive, check against the model, advance the model
  task automatic step(input logic v, input logic gr, input logic gw,
                      input logic [AW-1:0] va, input logic [AW-1:0] ga, input logic [DW-1:0] wd);
    int cand, grant, cdir;
    logic greq, starve_c, bub;
    op_t nop;
    vga_rd_en = v; gpu_rd_en = gr; gpu_wr_en = gw;
    vga_addr = va; gpu_addr = ga; gpu_wr_data = wd;
    #3;
    greq = gr | gw;
    starve_c = v && greq && (m_burst == BMAX);
    if (v && !starve_c) cand = 1;
    else if (greq) cand = gw ? 3 : 2;
    else cand = 0;
    cdir  = (cand == 0) ? 0 : ((cand == 3) ? 2 : 1);
    bub   = (cdir != 0) && (m_dir != 0) && (cdir != m_dir);
    grant = bub ? 0 : cand;
    chk("vga_rdy", vga_rdy, grant == 1);
    chk("gpu_rdy", gpu_rdy, grant >= 2);
    chk("gpu_starve", gpu_starve, (grant >= 2) && starve_c);
    chk("ce_n", sram_ce_n, m_prev.kind == 0);
    chk("oe_n", sram_oe_n, !(m_prev.kind == 1 || m_prev.kind == 2));
    chk("we_n", sram_we_n, m_prev.kind != 3);
    chk("dq_oe", sram_dq_oe, m_prev.kind == 3);
    if (m_prev.kind != 0) begin
      chk("sram_addr", sram_addr, m_prev.addr);
      chk("lb_ub_n", {sram_lb_n, sram_ub_n}, 2'b00);
    end
    if (m_prev.kind == 3) chk("dq_out", sram_dq_out, m_prev.data);
    chk("vga_rd_valid", vga_rd_valid, m_prev2.kind == 1);
    chk("gpu_rd_valid", gpu_rd_valid, m_prev2.kind == 2);
    if (m_prev2.kind == 1) chk("vga_rd_data", vga_rd_data, m_prev2.data);
    if (m_prev2.kind == 2) chk("gpu_rd_data", gpu_rd_data, m_prev2.data);
    obs_vga_rdy = vga_rdy; obs_gpu_rdy = gpu_rdy; obs_starve = gpu_starve;
    obs_vga_valid = vga_rd_valid; obs_gpu_valid = gpu_rd_valid;
    obs_gpu_data = gpu_rd_data; obs_we_n = sram_we_n;
    @(posedge clk_ir); #1;
    nop.kind = grant;
    nop.addr = (grant == 1) ? va : ga;
    if (grant == 3) begin
      nop.data = wd;
      ref_mem[nop.addr[9:0]] = wd;
    end else begin
      nop.data = ref_mem[nop.addr[9:0]];
    end
    m_prev2 = m_prev;
    m_prev  = nop;
    if (!greq || grant >= 2) m_burst = 0;
    else if (grant == 1 && m_burst < BMAX) m_burst++;
    m_dir = (grant == 0) ? 0 : ((grant == 3) ? 2 : 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_strobes"}, {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}, 5'h1f);
    chk({tag, "_dq_oe"}, sram_dq_oe, 1'b0);
    chk({tag, "_addr"}, sram_addr, '0);
    chk({tag, "_dq_out"}, sram_dq_out, '0);
    chk({tag, "_rdy"}, {vga_rdy, gpu_rdy}, 2'b00);
    chk({tag, "_valid"}, {vga_rd_valid, gpu_rd_valid}, 2'b00);
    chk({tag, "_starve"}, gpu_starve, 1'b0);
    chk({tag, "_rd_data"}, {vga_rd_data, gpu_rd_data}, '0);
  endtask

  typedef struct { logic v, gr, gw, exp_v, exp_g; } vec_t;
  vec_t tbl [13];

  initial begin
    int cnt_a, cnt_b, pos_err, bub;
    logic got, wr_pending;
    logic [23:0] pat;

    tbl[0]  = '{0, 0, 0, 0, 0};  // idle
    tbl[1]  = '{1, 0, 0, 1, 0};  // VGA alone
    tbl[2]  = '{0, 0, 1, 0, 0};  // write after read: bubble
    tbl[3]  = '{0, 0, 1, 0, 1};  // write granted
    tbl[4]  = '{0, 1, 1, 0, 1};  // rd+wr: write, same direction
    tbl[5]  = '{1, 0, 0, 0, 0};  // read after write: bubble
    tbl[6]  = '{1, 0, 0, 1, 0};
    tbl[7]  = '{0, 1, 0, 0, 1};  // GPU read, no bubble
    tbl[8]  = '{1, 1, 0, 1, 0};  // contention: VGA wins
    tbl[9]  = '{0, 0, 0, 0, 0};
    tbl[10] = '{0, 1, 1, 0, 1};  // after idle: write without bubble
    tbl[11] = '{1, 0, 0, 0, 0};
    tbl[12] = '{1, 0, 0, 1, 0};

    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
    model_clear();

    // reset, with a VGA request held to show rdy stays low
    rst_sync = 1'b1; vga_rd_en = 1'b1; gpu_rd_en = 1'b0; gpu_wr_en = 1'b0;
    vga_addr = '0; gpu_addr = '0; gpu_wr_data = '0;
    repeat (2) @(posedge clk_ir);
    #1;
    check_reset_outputs("rst");
    rst_sync = 1'b0; vga_rd_en = 1'b0;

    // vector table
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].v, tbl[i].gr, tbl[i].gw, AW'(i), AW'(i + 32), DW'(16'hA000 + i));
      chk($sformatf("tbl%0d_rdy", i), {obs_vga_rdy, obs_gpu_rdy}, {tbl[i].exp_v, tbl[i].exp_g});
    end
    idle(2);

    // continuous VGA reads 0..15
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, AW'(i), '0, '0);
      cnt_a += int'(obs_vga_rdy);
      cnt_b += int'(obs_vga_valid);
    end
    for (int i = 0; i < 2; i++) begin
      idle(1);
      cnt_b += int'(obs_vga_valid);
    end
    chk("vga_stream_rdy", cnt_a, 16);
    chk("vga_stream_valid", cnt_b, 16);

    // GPU write then read of the same address
    step(0, 0, 1, '0, AW'(16'h100), 16'h1234);
    chk("wr_granted", obs_gpu_rdy, 1'b1);
    bub = 0; got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      step(0, 1, 0, '0, AW'(16'h100), '0);
      if (obs_gpu_rdy) got = 1'b1;
      else bub++;
    end
    chk("rd_granted", got, 1'b1);
    chk("wr_rd_bubbles", bub, 1);
    idle(2);
    chk("wr_rd_valid", obs_gpu_valid, 1'b1);
    chk("wr_rd_data", obs_gpu_data, 16'h1234);

    // both read continuously: GPU every 9th cycle by starvation override
    idle(1);
    cnt_a = 0; cnt_b = 0; pos_err = 0;
    for (int c = 0; c < 27; c++) begin
      step(1, 1, 0, AW'(c), AW'(16'h200 + c), '0);
      if (obs_gpu_rdy) begin
        cnt_a++;
        if (c % 9 != 8) pos_err++;
      end
      cnt_b += int'(obs_starve);
    end
    chk("starve_gpu_grants", cnt_a, 3);
    chk("starve_pulses", cnt_b, 3);
    chk("starve_positions", pos_err, 0);
    idle(2);

    // GPU write waiting on a VGA stream: 8 V, bubble, W, bubble, V
    pat = '0; wr_pending = 1'b1; cnt_a = 0;
    for (int c = 0; c < 12; c++) begin
      step(1, 0, wr_pending, AW'(c), AW'(16'h300), 16'h5A5A);
      pat = {pat[21:0], obs_gpu_rdy, obs_vga_rdy};
      if (obs_gpu_rdy) wr_pending = 1'b0;
      cnt_a += int'(!obs_we_n);
    end
    idle(1);
    cnt_a += int'(!obs_we_n);
    chk("wr_in_stream_pattern", pat, 24'h555521);
    chk("wr_in_stream_we_pulses", cnt_a, 1);
    idle(1);

    // rd+wr together with VGA idle, then read back
    cnt_a = 0;
    step(0, 1, 1, '0, AW'(16'h40), 16'hBEEF);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      cnt_a += int'(obs_gpu_valid);
    end
    chk("both_en_no_valid", cnt_a, 0);
    step(0, 1, 0, '0, AW'(16'h40), '0);
    idle(2);
    chk("both_en_readback", obs_gpu_data, 16'hBEEF);

    // reset one cycle after a VGA accept
    step(1, 0, 0, AW'(5), '0, '0);
    chk("midrst_accept", obs_vga_rdy, 1'b1);
    rst_sync = 1'b1; vga_rd_en = 1'b0;
    @(posedge clk_ir); #1;
    check_reset_outputs("midrst");
    rst_sync = 1'b0;
    model_clear();
    cnt_a = 0;
    for (int i = 0; i < 2; i++) begin
      idle(1);
      cnt_a += int'(obs_vga_valid);
    end
    chk("midrst_no_valid", cnt_a, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
           AW'($urandom_range(0, 1023)), AW'($urandom_range(0, 1023)), DW'($urandom));
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
